uart_rx_frame_ctrl: RTL
=======================

# uart_rx_frame_ctrl

Parametrised UART receive controller for the UART RX path: one block that integrates the frame state machine, edge/bit counters, 3-sample majority-vote bit sampler, deserializer, and parity/stop checkers. It generalises the existing receiver in four ways:
- configurable data width;
- even/odd parity selection;
- one or two stop bits;
- break-condition detection.

It sits between the RX_IN pin synchroniser and the RX-side clock-domain crossing. It emits one parallel word per good frame.

## Interface
- DATA_WIDTH, 8: data bits per frame (5..9).
- PRESCALE_W, 6: width of Prescale.
- CLK  in  1  receiver oversampling clock.
- RST  in  1  asynchronous, active-low reset.
- RX_IN  in  1  serial input, already synchronised; idle high.
- Prescale  in  PRESCALE_W  oversampling ratio. Legal values are even and ≥ 8 (8, 16, 32 with default width).
- parity_enable  in  1  1 = parity bit present.
- parity_type  in  1  0 = even, 1 = odd.
- stop_bits  in  1  0 = one stop bit, 1 = two stop bits.
- P_DATA  out  DATA_WIDTH  last good received word.
- Data_Valid  out  1  one-cycle pulse: P_DATA updated.
- par_err  out  1  one-cycle pulse: parity mismatch.
- stp_err  out  1  one-cycle pulse: a stop sample read 0.
- strt_glitch  out  1  one-cycle pulse: false start bit.
- brk_det  out  1  one-cycle pulse: break frame.

## Operation
- **Config latch.** Prescale, parity_enable, parity_type and stop_bits are latched on every exit from IDLE or DONE into START. Changes mid-frame have no effect on the frame in progress.
- **edge_cnt.** Counts 0..Prescale_l−1 in every bit-period state, then wraps to 0 and increments bit_cnt.
- **Sampling.** RX_IN is sampled at edge_cnt = Prescale_l/2−1, Prescale_l/2 and Prescale_l/2+1. The bit value is the majority of the three samples (≥ 2 ones → 1).
- **State transitions** (all decisions taken at end of bit, edge_cnt = Prescale_l−1):
  - IDLE: RX_IN = 0 → START, counters cleared.
  - START:
    - voted bit 1 → IDLE, strt_glitch pulses.
    - otherwise → DATA, bit_cnt = 0.
  - DATA: the voted bit is shifted in LSB-first. After DATA_WIDTH bits → PARITY if parity_enable, else STOP.
  - PARITY: the voted bit is compared against the XOR of the data bits, inverted when parity_type = 1. Mismatch sets an internal parity-error flag.
  - STOP: one or two stop periods. Any voted stop bit = 0 sets an internal stop-error flag. At the end of the last stop period → DONE.
  - DONE (exactly one cycle):
    - outputs are updated (see Output rules);
    - RX_IN = 0 → START (back-to-back frame), else → IDLE.
- **Output rules in DONE:**
  - Data_Valid = 1 and P_DATA ← shift register only if there is no parity error and no stop error. Otherwise P_DATA holds its previous value.
  - par_err and stp_err pulse from the internal flags.
  - brk_det pulses when all data bits, the parity bit (if present) and the first stop bit are all 0. stp_err also pulses in that case.
- **Flags.** Internal error flags clear on entry to START.
- **Reset.** Asserting RST at any time, mid-frame included, forces IDLE and clears all counters, flags and the shift register. Reset values of all outputs are 0, P_DATA included.
- **Exclusivity.** Data_Valid is never asserted in the same cycle as par_err, stp_err or brk_det.

## Timing
- RX_IN falling edge first seen in IDLE at cycle t → START with edge_cnt = 0 at t+1. This one-cycle lag is intended. DONE follows the same lag for back-to-back frames.
- Frame length in bits: F = 1 + DATA_WIDTH + parity_enable + (stop_bits ? 2 : 1).
- DONE cycle = t + 1 + F·Prescale_l. All output pulses are registered and last exactly that one cycle.
  - Example: DATA_WIDTH = 8, no parity, 1 stop, Prescale = 8 → DONE at t+81.
- strt_glitch asserts at t + 1 + Prescale_l, the cycle after the START bit ends.
- A glitch shorter than Prescale_l/2 cycles around the start-bit midpoint is rejected; a single wrong sample of the three never flips a bit.

## Test plan
- **Good frame, no parity.** DATA_WIDTH = 8, Prescale = 8, 1 stop, byte 0xA5 → Data_Valid one cycle at t+81, P_DATA = 0xA5, no error pulses.
- **Even parity, good then bad.** Parity enabled, even, 2 stop bits, Prescale = 16:
  - 0x3C with parity 0 → Data_Valid, P_DATA = 0x3C.
  - next frame 0x3D with parity 0 → par_err pulse, no Data_Valid, P_DATA stays 0x3C.
- **Start glitch and noise tolerance.** RX_IN low for 3 cycles at Prescale = 8 → strt_glitch at t+9, return to IDLE, no Data_Valid. Separately, a single-cycle inversion at a data-bit midpoint → word still received correctly.
- **Break.** RX_IN held low for 2 full frames at Prescale = 8 → brk_det and stp_err pulse together in DONE, Data_Valid = 0.
- **Back-to-back, config change, reset.**
  - Two frames 0x11, 0x22 with no idle gap → two Data_Valid pulses, 0x11 then 0x22.
  - Prescale changed 8 → 16 mid-frame → the current frame still uses 8.
  - RST pulsed in DATA → all outputs 0, state IDLE, the next frame is received correctly.

Source files
------------

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: start/data/parity/stop FSM with 3-sample
// majority voting, LSB-first deserializer, parity/stop checking and break
// detection. Configuration is latched at the start of every frame.
module uart_rx_frame_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  parity_enable,
  input  logic                  parity_type,
  input  logic                  stop_bits,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  strt_glitch,
  output logic                  brk_det
);

  localparam int unsigned BW = $clog2(DATA_WIDTH);
  localparam logic [PRESCALE_W-1:0] PONE = PRESCALE_W'(1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StDone} state_e;

  state_e                  state;
  logic [PRESCALE_W-1:0]   presc_l;
  logic                    par_en_l;
  logic                    par_type_l;
  logic                    stop2_l;
  logic [PRESCALE_W-1:0]   edge_cnt;
  logic [BW-1:0]           bit_cnt;
  logic [2:0]              samp;
  logic [DATA_WIDTH-1:0]   shift;
  logic                    par_flag;
  logic                    stp_flag;
  logic                    all_zero;

  logic [PRESCALE_W-1:0]   half;
  logic                    bit_end;
  logic                    vote;
  logic                    stp_fin;
  logic                    brk_fin;
  logic                    good_fin;

  assign half     = presc_l >> 1;
  assign bit_end  = (edge_cnt == presc_l - PONE);
  assign vote     = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);
  // Final-stop-bit outcome folds in the vote being decided this cycle.
  assign stp_fin  = stp_flag | ~vote;
  // On the second stop bit, the first one was already folded into all_zero.
  assign brk_fin  = all_zero & (~vote | (bit_cnt != '0));
  assign good_fin = ~par_flag & ~stp_fin;

  // Frame FSM, counters, sampler, deserializer and registered output pulses.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= StIdle;
      presc_l     <= '0;
      par_en_l    <= 1'b0;
      par_type_l  <= 1'b0;
      stop2_l     <= 1'b0;
      edge_cnt    <= '0;
      bit_cnt     <= '0;
      samp        <= '0;
      shift       <= '0;
      par_flag    <= 1'b0;
      stp_flag    <= 1'b0;
      all_zero    <= 1'b0;
      P_DATA      <= '0;
      Data_Valid  <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
      strt_glitch <= 1'b0;
      brk_det     <= 1'b0;
    end else begin
      Data_Valid  <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
      strt_glitch <= 1'b0;
      brk_det     <= 1'b0;

      if (edge_cnt == half - PONE) samp[0] <= RX_IN;
      if (edge_cnt == half)        samp[1] <= RX_IN;
      if (edge_cnt == half + PONE) samp[2] <= RX_IN;

      if (state != StIdle && state != StDone) begin
        edge_cnt <= bit_end ? '0 : edge_cnt + PONE;
      end

      unique case (state)
        StIdle, StDone: begin
          edge_cnt <= '0;
          if (!RX_IN) begin
            state      <= StStart;
            presc_l    <= Prescale;
            par_en_l   <= parity_enable;
            par_type_l <= parity_type;
            stop2_l    <= stop_bits;
            bit_cnt    <= '0;
            par_flag   <= 1'b0;
            stp_flag   <= 1'b0;
            all_zero   <= 1'b1;
          end else begin
            state <= StIdle;
          end
        end
        StStart: if (bit_end) begin
          if (vote) begin
            state       <= StIdle;
            strt_glitch <= 1'b1;
          end else begin
            state   <= StData;
            bit_cnt <= '0;
          end
        end
        StData: if (bit_end) begin
          shift    <= {vote, shift[DATA_WIDTH-1:1]};
          all_zero <= all_zero & ~vote;
          if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
            bit_cnt <= '0;
            state   <= par_en_l ? StParity : StStop;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        StParity: if (bit_end) begin
          par_flag <= vote ^ (^shift) ^ par_type_l;
          all_zero <= all_zero & ~vote;
          bit_cnt  <= '0;
          state    <= StStop;
        end
        StStop: if (bit_end) begin
          if (stop2_l && bit_cnt == '0) begin
            bit_cnt  <= BW'(1);
            stp_flag <= stp_fin;
            all_zero <= all_zero & ~vote;
          end else begin
            state      <= StDone;
            Data_Valid <= good_fin;
            par_err    <= par_flag;
            stp_err    <= stp_fin;
            brk_det    <= brk_fin;
            if (good_fin) P_DATA <= shift;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
